// File: rtl/multiplicador_seq_arbitro.sv
// multiplicador_seq_arbitro
// Sequential shift-and-add W x W multiplier shared by two requesters.
// Round-robin arbitration picks one requester in IDLE. The product is then
// built one partial-product add per clock on a single W+1-bit adder, and
// the 2W-bit result is returned with the owning requester's ID over a
// valid/ready port.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req0_valid/a/b/ready requester 0 operand handshake
//   req1_valid/a/b/ready requester 1 operand handshake
//   res_valid/p/id/ready result handshake (res_* registered)
//   busy                 high whenever the engine is not in IDLE
module multiplicador_seq_arbitro #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           req1_ready,
  output logic           res_valid,
  output logic [2*W-1:0] res_p,
  output logic           res_id,
  input  logic           res_ready,
  output logic           busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [2*W-1:0] p_reg;
  logic [CW-1:0]  cnt;
  logic           id_reg;
  logic           last_grant;

  logic           grant0;
  logic           grant1;
  logic [W-1:0]   addend;
  logic [W:0]     sum;
  logic [2*W-1:0] p_next;

  // On a tie the requester not served last wins; last_grant resets to 1
  // so requester 0 takes the first tie.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign req0_ready = ~rst & (state == IDLE) & grant0;
  assign req1_ready = ~rst & (state == IDLE) & grant1;
  assign busy       = (state != IDLE);

  // Add into the upper half, then shift the whole product right by one.
  // The carry lands in the top bit of the shifted product.
  always_comb begin
    addend = b_reg[0] ? a_reg : '0;
    sum    = {1'b0, p_reg[2*W-1:W]} + {1'b0, addend};
    p_next = {sum, p_reg[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      p_reg      <= '0;
      cnt        <= '0;
      id_reg     <= 1'b0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_p      <= '0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            a_reg      <= grant1 ? req1_a : req0_a;
            b_reg      <= grant1 ? req1_b : req0_b;
            p_reg      <= '0;
            cnt        <= '0;
            id_reg     <= grant1;
            last_grant <= grant1;
            state      <= ITER;
          end
        end
        ITER: begin
          p_reg <= p_next;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_p     <= p_next;
            res_id    <= id_reg;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_seq_arbitro.sv
// Directed bench for multiplicador_seq_arbitro (W=4): reset values, single
// operation latency, corner operands, round-robin contention, result
// backpressure, reset during iteration and an exhaustive operand sweep.
module tb_multiplicador_seq_arbitro;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       res_valid;
  logic [7:0] res_p;
  logic       res_id;
  logic       res_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  multiplicador_seq_arbitro #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_p(res_p), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && res_valid && res_ready) hs_count <= hs_count + 1;

  // Present operands on one port until accepted; returns one cycle after
  // the accept edge's settle point, valids dropped.
  task automatic issue(input int port, input logic [3:0] a, input logic [3:0] b, output bit ok);
    ok = 1'b0;
    if (port == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else           begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Edges until res_valid is seen; -1 if it never appears.
  task automatic wait_result(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin n = i; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'd3; req0_b = 4'd3; req1_a = 4'd3; req1_b = 4'd3;
    res_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if (res_valid !== 1'b0 || res_p !== 8'h00 || res_id !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got v=%b p=%h id=%b busy=%b want 0 00 0 0",
                         res_valid, res_p, res_id, busy);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL idle_noreq_ready got %b%b want 00", req0_ready, req1_ready);
    end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    res_ready = 1'b1;
    issue(0, 4'd13, 4'd11, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept got 0 want 1"); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    wait_result(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL single_latency got %0d want 4", n); end
    checks++;
    if (res_p !== 8'h8F || res_id !== 1'b0) begin
      errors++; $display("FAIL single_result got p=%h id=%b want 8f 0", res_p, res_id);
    end
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after got v=%b busy=%b want 0 0", res_valid, busy);
    end
    checks++;
    if (res_p !== 8'h8F || res_id !== 1'b0) begin
      errors++; $display("FAIL single_hold got p=%h id=%b want 8f 0", res_p, res_id);
    end
  endtask

  task automatic test_corners();
    logic [3:0] ta [5] = '{4'd15, 4'd0, 4'd9, 4'd1, 4'd8};
    logic [3:0] tb [5] = '{4'd15, 4'd9, 4'd0, 4'd1, 4'd8};
    logic [7:0] tp [5] = '{8'd225, 8'd0, 8'd0, 8'd1, 8'd64};
    bit ok;
    int n;
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(1, ta[i], tb[i], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL corner_accept[%0d] got 0 want 1", i); continue; end
      wait_result(n);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL corner_latency[%0d] got %0d want 4", i, n); end
      checks++;
      if (res_p !== tp[i] || res_id !== 1'b1) begin
        errors++; $display("FAIL corner_result[%0d] got p=%0d id=%b want %0d 1", i, res_p, res_id, tp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_contention();
    int acc_cyc [$];
    int acc_port [$];
    logic [7:0] rp [$];
    logic rid [$];
    res_ready = 1'b1;
    do_reset();
    req0_a = 4'd3; req0_b = 4'd5; req1_a = 4'd7; req1_b = 4'd6;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      #1;
      checks++;
      if (req0_ready && req1_ready) begin errors++; $display("FAIL cont_both_ready cycle %0d got 11 want one-hot", c); end
      if (req0_ready) begin acc_cyc.push_back(c); acc_port.push_back(0); end
      if (req1_ready) begin acc_cyc.push_back(c); acc_port.push_back(1); end
      if (res_valid) begin rp.push_back(res_p); rid.push_back(res_id); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (acc_cyc.size() != 4 || rp.size() != 4) begin
      errors++; $display("FAIL cont_counts got acc=%0d res=%0d want 4 4", acc_cyc.size(), rp.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_cyc[i] != 6 * i || acc_port[i] != i % 2) begin
          errors++; $display("FAIL cont_grant[%0d] got cyc=%0d port=%0d want %0d %0d",
                             i, acc_cyc[i], acc_port[i], 6 * i, i % 2);
        end
        checks++;
        if (rid[i] !== 1'(i % 2) || rp[i] !== ((i % 2 == 0) ? 8'd15 : 8'd42)) begin
          errors++; $display("FAIL cont_result[%0d] got p=%0d id=%b want %0d %0d",
                             i, rp[i], rid[i], (i % 2 == 0) ? 15 : 42, i % 2);
        end
      end
    end
    // drain the last result (already handshaken at cycle 23's edge)
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    res_ready = 1'b0;
    issue(0, 4'd6, 4'd7, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_accept got 0 want 1"); end
    wait_result(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_latency got %0d want 4", n); end
    req0_a = 4'd1; req0_b = 4'd1; req1_a = 4'd2; req1_b = 4'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b1 ||
          res_p !== 8'd42 || res_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got rdy=%b%b v=%b p=%0d id=%b want 00 1 42 0",
                           i, req0_ready, req1_ready, res_valid, res_p, res_id);
      end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got v=%b busy=%b want 0 0", res_valid, busy);
    end
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_next_grant got rdy=%b%b want 01", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(n);
    checks++;
    if (n !== 4 || res_p !== 8'd6 || res_id !== 1'b1) begin
      errors++; $display("FAIL bp_next_result got n=%0d p=%0d id=%b want 4 6 1", n, res_p, res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_iter();
    bit ok;
    int n;
    res_ready = 1'b1;
    issue(0, 4'd12, 4'd10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rmi_accept got 0 want 1"); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    req0_a = 4'd5; req0_b = 4'd9; req1_a = 4'd2; req1_b = 4'd2;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rmi_ready_in_rst got %b%b want 00", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_p !== 8'd0 || res_id !== 1'b0) begin
      errors++; $display("FAIL rmi_cleared got busy=%b v=%b p=%0d id=%b want 0 0 0 0",
                         busy, res_valid, res_p, res_id);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rmi_grant got rdy=%b%b want 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_result(n);
    checks++;
    if (n !== 4 || res_p !== 8'd45 || res_id !== 1'b0) begin
      errors++; $display("FAIL rmi_result got n=%0d p=%0d id=%b want 4 45 0", n, res_p, res_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    bit ok;
    int n;
    int hs_start;
    int stall;
    logic [7:0] k8;
    logic [3:0] a, b;
    logic [7:0] ep;
    res_ready = 1'b0;
    hs_start = hs_count;
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      a = k8[7:4];
      b = k8[3:0];
      ep = {4'b0, a} * {4'b0, b};
      issue(k % 2, a, b, ok);
      if (!ok) begin
        checks++; errors++; $display("FAIL exh_accept[%0d] got 0 want 1", k);
        continue;
      end
      wait_result(n);
      stall = $urandom_range(0, 3);
      repeat (stall) begin @(posedge clk); #1; end
      checks++;
      if (n !== 4 || res_valid !== 1'b1 || res_p !== ep || res_id !== 1'(k % 2)) begin
        errors++; $display("FAIL exh_result[%0d] got n=%0d v=%b p=%0d id=%b want 4 1 %0d %0d",
                           k, n, res_valid, res_p, res_id, ep, k % 2);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++; $display("FAIL exh_drop[%0d] got v=%b want 0", k, res_valid);
      end
    end
    checks++;
    if (hs_count - hs_start != 256) begin
      errors++; $display("FAIL exh_handshakes got %0d want 256", hs_count - hs_start);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_corners();
    test_contention();
    test_backpressure();
    test_reset_mid_iter();
    test_exhaustive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
